// File: rtl/filter_biquad_cascade_if.sv
// ============================================================================
// Module      : filter_biquad_cascade_if
// Description : Sample stream, coefficient port and status bundle for the biquad cascade.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface filter_biquad_cascade_if #(
    parameter int DATA_SIZE = 24,
    parameter int COEF_SIZE = 20,
    parameter int SECTIONS  = 4
);
    localparam int ADDR_W = $clog2(SECTIONS) + 3;

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] data_in;
    logic                 out_valid;
    logic [DATA_SIZE-1:0] data_out;
    logic                 coef_we;
    logic [ADDR_W-1:0]    coef_addr;
    logic [COEF_SIZE-1:0] coef_data;
    logic                 coef_err;
    logic                 clear_st;
    logic                 overrun;

    modport master (
        output in_valid, data_in, coef_we, coef_addr, coef_data, clear_st,
        input  in_ready, out_valid, data_out, coef_err, overrun
    );

    modport slave (
        input  in_valid, data_in, coef_we, coef_addr, coef_data, clear_st,
        output in_ready, out_valid, data_out, coef_err, overrun
    );
endinterface

`default_nettype wire

// File: rtl/filter_biquad_cascade.sv
// ============================================================================
// Module      : filter_biquad_cascade
// Description : Time-multiplexed cascade of transposed DF-II biquads with loadable
//               coefficients and an output gain; FILTER_SAT_EN selects saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_biquad_cascade #(
    parameter int COEF_SIZE = 20,
    parameter int FRAC_BITS = 18,
    parameter int DATA_SIZE = 24,
    parameter int GUARD     = 4,
    parameter int SECTIONS  = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    filter_biquad_cascade_if.slave bus
);
    localparam int W      = DATA_SIZE + GUARD;
    localparam int PW     = COEF_SIZE + W + 2;
    localparam int KW     = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int ADDR_W = $clog2(SECTIONS) + 3;

    localparam logic signed [COEF_SIZE-1:0] C_ONE   = COEF_SIZE'(1 << FRAC_BITS);
    localparam logic        [KW-1:0]        C_KLAST = KW'(SECTIONS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEC  = 2'd1,
        S_GAIN = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic        [KW-1:0]        k_q, k_d;
    logic signed [W-1:0]         y_q, y_d;
    logic        [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                        out_valid_q, out_valid_d;
    logic                        coef_err_q;
    logic                        overrun_q;

    logic signed [W-1:0]         s1_q [SECTIONS];
    logic signed [W-1:0]         s2_q [SECTIONS];
    logic signed [COEF_SIZE-1:0] b0_q [SECTIONS];
    logic signed [COEF_SIZE-1:0] b1_q [SECTIONS];
    logic signed [COEF_SIZE-1:0] b2_q [SECTIONS];
    logic signed [COEF_SIZE-1:0] a1_q [SECTIONS];
    logic signed [COEF_SIZE-1:0] a2_q [SECTIONS];
    logic signed [COEF_SIZE-1:0] gain_q;

    // Handshake and coefficient-port decode
    logic              w_idle, w_accept, w_clear;
    logic [2:0]        w_idx;
    logic [ADDR_W-1:0] w_secf;
    logic [KW-1:0]     w_sec;
    logic              w_is_gain, w_addr_ok, w_coef_ok;

    assign w_idle    = (state_q == S_IDLE);
    assign w_accept  = bus.in_valid && w_idle;
    assign w_clear   = bus.clear_st && w_idle;
    assign w_idx     = bus.coef_addr[2:0];
    assign w_secf    = bus.coef_addr >> 3;
    assign w_sec     = w_secf[KW-1:0];
    assign w_is_gain = (bus.coef_addr == ADDR_W'(7));
    assign w_addr_ok = w_is_gain || ((w_secf < ADDR_W'(SECTIONS)) && (w_idx <= 3'd4));
    assign w_coef_ok = bus.coef_we && w_idle && !w_accept && w_addr_ok;

    // Shared datapath; multiplier 0 carries b0*x in SEC and y*GAIN in GAIN
    logic signed [PW-1:0] w_x_e, w_y_e, w_s1k_e, w_s2k_e;
    logic signed [PW-1:0] w_c0_e, w_b1_e, w_b2_e, w_a1_e, w_a2_e;
    logic signed [PW-1:0] w_p0, w_pb1, w_pb2, w_pa1, w_pa2;
    logic signed [PW-1:0] w_p0sh, w_ysum, w_s1sum, w_s2sum;
    logic signed [W-1:0]  w_y_new, w_s1_new, w_s2_new;
    logic [DATA_SIZE-1:0] w_gain_out;

    assign w_x_e   = PW'(y_q);
    assign w_s1k_e = PW'(s1_q[k_q]);
    assign w_s2k_e = PW'(s2_q[k_q]);
    assign w_c0_e  = (state_q == S_GAIN) ? PW'(gain_q) : PW'(b0_q[k_q]);
    assign w_b1_e  = PW'(b1_q[k_q]);
    assign w_b2_e  = PW'(b2_q[k_q]);
    assign w_a1_e  = PW'(a1_q[k_q]);
    assign w_a2_e  = PW'(a2_q[k_q]);

    assign w_p0    = w_c0_e * w_x_e;
    assign w_pb1   = w_b1_e * w_x_e;
    assign w_pb2   = w_b2_e * w_x_e;
    assign w_y_e   = PW'(w_y_new);
    assign w_pa1   = w_a1_e * w_y_e;
    assign w_pa2   = w_a2_e * w_y_e;

    assign w_p0sh  = w_p0 >>> FRAC_BITS;
    assign w_ysum  = w_p0sh + w_s1k_e;
    assign w_s1sum = ((w_pb1 - w_pa1) >>> FRAC_BITS) + w_s2k_e;
    assign w_s2sum = (w_pb2 - w_pa2) >>> FRAC_BITS;

`ifdef FILTER_SAT_EN
    localparam logic signed [PW-1:0] C_WMAX_E = PW'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [PW-1:0] C_WMIN_E = ~C_WMAX_E;
    localparam logic signed [PW-1:0] C_DMAX_E = PW'({1'b0, {(DATA_SIZE-1){1'b1}}});
    localparam logic signed [PW-1:0] C_DMIN_E = ~C_DMAX_E;

    function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
        if (v > C_WMAX_E)      sat_w = {1'b0, {(W-1){1'b1}}};
        else if (v < C_WMIN_E) sat_w = {1'b1, {(W-1){1'b0}}};
        else                   sat_w = v[W-1:0];
    endfunction

    function automatic logic [DATA_SIZE-1:0] sat_d(input logic signed [PW-1:0] v);
        if (v > C_DMAX_E)      sat_d = {1'b0, {(DATA_SIZE-1){1'b1}}};
        else if (v < C_DMIN_E) sat_d = {1'b1, {(DATA_SIZE-1){1'b0}}};
        else                   sat_d = v[DATA_SIZE-1:0];
    endfunction

    assign w_y_new    = sat_w(w_ysum);
    assign w_s1_new   = sat_w(w_s1sum);
    assign w_s2_new   = sat_w(w_s2sum);
    assign w_gain_out = sat_d(w_p0sh);
`else
    logic w_unused_hi;

    assign w_y_new     = w_ysum[W-1:0];
    assign w_s1_new    = w_s1sum[W-1:0];
    assign w_s2_new    = w_s2sum[W-1:0];
    assign w_gain_out  = w_p0sh[DATA_SIZE-1:0];
    assign w_unused_hi = ^{w_ysum[PW-1:W], w_s1sum[PW-1:W], w_s2sum[PW-1:W],
                           w_p0sh[PW-1:DATA_SIZE]};
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        y_d         = y_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    y_d     = W'($signed(bus.data_in));
                    k_d     = '0;
                    state_d = S_SEC;
                end
            end
            S_SEC: begin
                y_d = w_y_new;
                if (k_q == C_KLAST) begin
                    k_d     = '0;
                    state_d = S_GAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_GAIN: begin
                data_out_d  = w_gain_out;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            y_q         <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            gain_q      <= C_ONE;
            for (int i = 0; i < SECTIONS; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
                b0_q[i] <= C_ONE;
                b1_q[i] <= '0;
                b2_q[i] <= '0;
                a1_q[i] <= '0;
                a2_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            y_q         <= y_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            coef_err_q  <= bus.coef_we && !w_coef_ok;
            if (bus.in_valid && !w_idle) overrun_q <= 1'b1;

            // Clear is IDLE-only and section updates are SEC-only, so they never collide
            if (w_clear) begin
                for (int i = 0; i < SECTIONS; i++) begin
                    s1_q[i] <= '0;
                    s2_q[i] <= '0;
                end
            end else if (state_q == S_SEC) begin
                s1_q[k_q] <= w_s1_new;
                s2_q[k_q] <= w_s2_new;
            end

            if (w_coef_ok) begin
                case (w_idx)
                    3'd0:    b0_q[w_sec] <= $signed(bus.coef_data);
                    3'd1:    b1_q[w_sec] <= $signed(bus.coef_data);
                    3'd2:    b2_q[w_sec] <= $signed(bus.coef_data);
                    3'd3:    a1_q[w_sec] <= $signed(bus.coef_data);
                    3'd4:    a2_q[w_sec] <= $signed(bus.coef_data);
                    default: gain_q      <= $signed(bus.coef_data);
                endcase
            end
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.coef_err  = coef_err_q;
    assign bus.overrun   = overrun_q;

endmodule

`default_nettype wire
